mem_pipe_stage: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline. It sits directly downstream of the execute stage and consumes that stage's ALU result and store-data output.
- Contains three parts: the EX/MEM pipeline register, a word-addressed synchronous data memory, and the MEM/WB pipeline register.
- Produces two values that the execute stage's forwarding muxes use: `ex_mem_alu_result` and `mem_wb_write_back_result`.

---
 rtl/mem_pipe_stage.sv | 109 ++++++++++
 tb/tb_mem_pipe_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_stage.sv
// MIPS memory stage: EX/MEM register, word-addressed synchronous data memory, MEM/WB register.
// Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned accesses and flags them on mem_misaligned.
module mem_pipe_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [4:0]        ex_mem_rd,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic [4:0]        mem_wb_rd,
  output logic              mem_wb_reg_write,
  output logic [DATA_W-1:0] mem_wb_write_back_result,
  output logic              mem_misaligned
);

  logic [DATA_W-1:0] ex_mem_store_data;
  logic              ex_mem_mem_to_reg;
  logic              ex_mem_mem_write;

  logic [DATA_W-1:0] mem_wb_alu_result;
  logic [DATA_W-1:0] mem_wb_read_data;
  logic              mem_wb_mem_to_reg;

  logic [DATA_W-1:0] dmem [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic              misalign;
  logic              wr_en;

  assign word_idx = ex_mem_alu_result[ADDR_W+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = (ex_mem_mem_read || ex_mem_mem_write) && (ex_mem_alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign wr_en = ex_mem_mem_write && !stall && !reset && !misalign;

  // ---- EX -> MEM boundary ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_rd         <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else if (!stall) begin
      ex_mem_alu_result <= ex_alu_result;
      ex_mem_store_data <= ex_store_data;
      ex_mem_rd         <= ex_rd;
      ex_mem_reg_write  <= ex_reg_write;
      ex_mem_mem_to_reg <= ex_mem_to_reg;
      ex_mem_mem_read   <= ex_mem_read;
      ex_mem_mem_write  <= ex_mem_write;
    end
  end

  // ---- data memory (contents are never reset) ----
  always_ff @(posedge clk) begin
    if (wr_en)
      dmem[word_idx] <= ex_mem_store_data;
  end

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      mem_wb_alu_result <= '0;
      mem_wb_read_data  <= '0;
      mem_wb_rd         <= '0;
      mem_wb_reg_write  <= 1'b0;
      mem_wb_mem_to_reg <= 1'b0;
    end else begin
      mem_wb_alu_result <= ex_mem_alu_result;
      mem_wb_read_data  <= ex_mem_mem_read ? dmem[word_idx] : '0;
      mem_wb_rd         <= ex_mem_rd;
      mem_wb_reg_write  <= ex_mem_reg_write && !misalign;
      mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Flag rides with the MEM/WB slot, so a stall bubble clears it.
  always_ff @(posedge clk) begin
    if (reset || stall)
      mem_misaligned <= 1'b0;
    else
      mem_misaligned <= misalign;
  end
`else
  assign mem_misaligned = 1'b0;
`endif

  assign mem_wb_write_back_result = mem_wb_mem_to_reg ? mem_wb_read_data : mem_wb_alu_result;

endmodule

// File: tb/tb_mem_pipe_stage.sv
// Scoreboard bench for mem_pipe_stage: an instruction-level reference model predicts
// per-cycle EX/MEM contents and the ordered stream of register writebacks.
module tb_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [31:0] ex_mem_alu_result;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write, ex_mem_mem_read;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_reg_write;
  logic [31:0] mem_wb_write_back_result;
  logic        mem_misaligned;

  always #5 clk = ~clk;

  mem_pipe_stage #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rd(ex_mem_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_write_back_result(mem_wb_write_back_result), .mem_misaligned(mem_misaligned)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, m2r, mr, mw;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw, mr, mis;
  } cyc_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  cyc_t        cyc_q[$];
  wb_t         wb_q[$];
  logic [31:0] ref_mem [256];
  instr_t      held;
  int          checks = 0;
  int          passes = 0;

  function automatic instr_t nop();
    instr_t t;
    t.alu = 0; t.sd = 0; t.rd = 0; t.rw = 0; t.m2r = 0; t.mr = 0; t.mw = 0;
    return t;
  endfunction

  function automatic instr_t rtype(logic [31:0] v, logic [4:0] rd);
    instr_t t = nop();
    t.alu = v; t.rd = rd; t.rw = 1'b1;
    return t;
  endfunction

  function automatic instr_t lw(logic [31:0] a, logic [4:0] rd);
    instr_t t = nop();
    t.alu = a; t.rd = rd; t.rw = 1'b1; t.m2r = 1'b1; t.mr = 1'b1;
    return t;
  endfunction

  function automatic instr_t sw(logic [31:0] a, logic [31:0] d);
    instr_t t = nop();
    t.alu = a; t.sd = d; t.rd = 5'($urandom_range(0, 31)); t.mw = 1'b1;
    return t;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Executes the instruction leaving the memory stage, in program order.
  task automatic retire(input instr_t t, output logic mis);
    wb_t w;
    mis = CHK_EN && (t.mr || t.mw) && (t.alu % 4 != 0);
    if (t.mw && !mis) ref_mem[widx(t.alu)] = t.sd;
    if (t.rw && !mis) begin
      w.rd  = t.rd;
      w.val = t.m2r ? ref_mem[widx(t.alu)] : t.alu;
      wb_q.push_back(w);
    end
  endtask

  // Applies one cycle of inputs (called at the falling edge) and records expectations.
  task automatic drive(input logic rs, input logic st, input logic fl, input instr_t t);
    cyc_t c;
    logic mis = 1'b0;
    reset = rs; stall = st; flush = fl;
    ex_alu_result = t.alu; ex_store_data = t.sd; ex_rd = t.rd;
    ex_reg_write = t.rw; ex_mem_to_reg = t.m2r; ex_mem_read = t.mr; ex_mem_write = t.mw;
    if (rs) held = nop();
    else if (!st) begin
      retire(held, mis);
      held = fl ? nop() : t;
    end else if (fl) held = nop();
    c.alu = held.alu; c.rd = held.rd; c.rw = held.rw; c.mr = held.mr; c.mis = mis;
    cyc_q.push_back(c);
    @(negedge clk);
  endtask

  task automatic issue(input instr_t t);
    drive(1'b0, 1'b0, 1'b0, t);
  endtask

  // Monitor: compares DUT outputs just after each rising edge.
  initial begin
    cyc_t c;
    wb_t  w;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        chk("ex_mem_alu_result", ex_mem_alu_result, c.alu);
        chk("ex_mem_ctl", {27'd0, ex_mem_rd}, {27'd0, c.rd});
        chk("ex_mem_flags", {30'd0, ex_mem_reg_write, ex_mem_mem_read}, {30'd0, c.rw, c.mr});
        chk("mem_misaligned", {31'd0, mem_misaligned}, {31'd0, c.mis});
        if (mem_wb_reg_write === 1'b1) begin
          if (wb_q.size() == 0) begin
            chk("wb_unexpected_write", {27'd0, mem_wb_rd}, 32'hFFFF_FFFF);
          end else begin
            w = wb_q.pop_front();
            chk("mem_wb_rd", {27'd0, mem_wb_rd}, {27'd0, w.rd});
            chk("mem_wb_write_back_result", mem_wb_write_back_result, w.val);
          end
        end else if (mem_wb_reg_write !== 1'b0) begin
          chk("mem_wb_reg_write_known", {31'd0, mem_wb_reg_write}, 32'd0);
        end
      end
    end
  end

  initial begin
    instr_t t;
    int     k;
    logic [31:0] a;
    held = nop();
    drive(1'b1, 1'b0, 1'b0, nop());
    drive(1'b1, 1'b0, 1'b0, nop());
    issue(nop());
    // Reset/idle state seen directly.
    chk("reset_ex_mem_alu", ex_mem_alu_result, 32'd0);
    chk("reset_ex_mem_bits", {25'd0, ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read}, 32'd0);
    chk("reset_mem_wb_bits", {25'd0, mem_wb_rd, mem_wb_reg_write, mem_misaligned}, 32'd0);
    chk("reset_wb_result", mem_wb_write_back_result, 32'd0);

    for (int i = 0; i < 256; i++) issue(sw(32'(i * 4), $urandom()));

    issue(sw(32'h10, 32'hDEADBEEF));
    issue(lw(32'h10, 5'd5));
    issue(rtype(32'h7, 5'd3));
    issue(nop());
    issue(nop());

    issue(sw(32'h20, 32'h12345678));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, rtype($urandom(), 5'd9));
    issue(lw(32'h20, 5'd6));

    drive(1'b0, 1'b0, 1'b1, sw(32'h30, 32'hFFFFFFFF));
    issue(lw(32'h30, 5'd7));

    issue(sw(32'h41, 32'hAAAA5555));
    issue(lw(32'h40, 5'd8));
    issue(lw(32'h43, 5'd10));

    // Stall and flush together kill the held instruction.
    issue(rtype(32'h55, 5'd11));
    drive(1'b0, 1'b1, 1'b1, rtype(32'h66, 5'd12));
    issue(nop());

    // Reset discards an in-flight store.
    issue(sw(32'h50, 32'hCAFEF00D));
    drive(1'b1, 1'b0, 1'b0, nop());
    issue(lw(32'h50, 5'd13));

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      a = {22'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (k)
        0: t = nop();
        1: t = rtype($urandom(), 5'($urandom_range(1, 31)));
        2: t = lw(a, 5'($urandom_range(1, 31)));
        default: t = sw(a, $urandom());
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) == 0, t);
    end

    for (int i = 0; i < 4; i++) issue(nop());
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
